div_arb_seq: RTL

// - Sequential restoring divider shared by two requesters through a round-robin arbiter.
// - Accepts one unsigned X/Y pair at a time and produces one quotient bit per clock.
// - Returns the quotient, a divide-by-zero flag and the requester ID on one response channel.
// - Sits between the arithmetic users and the divider datapath; replaces per-user combinational dividers.

---
 rtl/div_arb_seq_if.sv | 43 ++++
 rtl/div_arb_seq.sv | 133 +++++++++++++
 2 files changed

// File: rtl/div_arb_seq_if.sv
// Handshake bundle for div_arb_seq: two requester channels and one response channel.
// rsp_r is present only when DIV_REMAINDER_EN is defined.
interface div_arb_seq_if #(
    parameter int WD = 8
);
    // Valid/ready: a transfer happens on a rising edge where valid & ready are both high.
    // The source holds valid and its payload stable until that transfer.
    // readyN may depend combinationally on validN.
    logic          req0_valid;
    logic          req0_ready;
    logic [WD-1:0] req0_x;
    logic [WD-1:0] req0_y;
    logic          req1_valid;
    logic          req1_ready;
    logic [WD-1:0] req1_x;
    logic [WD-1:0] req1_y;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [WD-1:0] rsp_q;
    logic          rsp_dbz;
`ifdef DIV_REMAINDER_EN
    logic [WD-1:0] rsp_r;

    modport slave (
        input  req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_q, rsp_dbz, rsp_r
    );
    modport master (
        output req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_q, rsp_dbz, rsp_r
    );
`else
    modport slave (
        input  req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_q, rsp_dbz
    );
    modport master (
        output req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_q, rsp_dbz
    );
`endif
endinterface

// File: rtl/div_arb_seq.sv
// Sequential restoring divider, one quotient bit per clock, shared by two round-robin requesters.
// Optional remainder output: define DIV_REMAINDER_EN.
module div_arb_seq #(
    parameter int WD = 8
) (
    input  logic              clk,
    input  logic              rst,
    div_arb_seq_if.slave      bus,
    output logic              busy,
    output logic [1:0]        o_dbg_state
);
    localparam int CW = $clog2(WD + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_rr;
    logic            r_id;
    logic            r_dbz;
    logic [WD-1:0]   r_a;
    logic [WD-1:0]   r_p;
    logic [WD-1:0]   r_y;
    logic [CW-1:0]   r_cnt;

    logic            w_gnt_vld;
    logic            w_gnt_id;
    logic [WD-1:0]   w_x;
    logic [WD-1:0]   w_y;
    logic [WD:0]     w_p_sh;
    logic [WD:0]     w_diff;
    logic [WD-1:0]   w_p_nxt;
    logic [WD-1:0]   w_a_nxt;

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = 1'b0;
        if (r_state == S_IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = ~r_rr;
            end else if (bus.req0_valid) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = 1'b0;
            end else if (bus.req1_valid) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = 1'b1;
            end
        end
    end

    assign w_x = w_gnt_id ? bus.req1_x : bus.req0_x;
    assign w_y = w_gnt_id ? bus.req1_y : bus.req0_y;

    // A negative trial difference means the restore path keeps the shifted remainder.
    always_comb begin
        w_p_sh  = {r_p, r_a[WD-1]};
        w_diff  = w_p_sh - {1'b0, r_y};
        w_p_nxt = w_diff[WD-1:0];
        w_a_nxt = {r_a[WD-2:0], 1'b1};
        if (w_diff[WD]) begin
            w_p_nxt = w_p_sh[WD-1:0];
            w_a_nxt = {r_a[WD-2:0], 1'b0};
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_gnt_vld) w_next = (w_y == '0) ? S_DONE : S_RUN;
            S_RUN:  if (r_cnt == CW'(1)) w_next = S_DONE;
            S_DONE: if (bus.rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rr    <= 1'b1;
            r_id    <= 1'b0;
            r_dbz   <= 1'b0;
            r_a     <= '0;
            r_p     <= '0;
            r_y     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_rr  <= w_gnt_id;
                        r_id  <= w_gnt_id;
                        r_y   <= w_y;
                        r_cnt <= CW'(WD);
                        if (w_y == '0) begin
                            r_a   <= '1;
                            r_p   <= w_x;
                            r_dbz <= 1'b1;
                        end else begin
                            r_a   <= w_x;
                            r_p   <= '0;
                            r_dbz <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    r_a   <= w_a_nxt;
                    r_p   <= w_p_nxt;
                    r_cnt <= r_cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = w_gnt_vld & ~w_gnt_id;
    assign bus.req1_ready = w_gnt_vld & w_gnt_id;
    assign bus.rsp_valid  = (r_state == S_DONE);
    assign bus.rsp_id     = r_id;
    assign bus.rsp_q      = r_a;
    assign bus.rsp_dbz    = r_dbz;
`ifdef DIV_REMAINDER_EN
    assign bus.rsp_r      = r_p;
`endif
    assign busy           = (r_state != S_IDLE);
    assign o_dbg_state    = r_state;
endmodule
